regfile_mp: RTL and testbench

- Parametrised successor to the integer register file.
- Configurable width, depth, read-port count and write-port count.
- Adds asynchronous reset, a defined write-port priority, an optional write-first bypass, and a per-register pending scoreboard for load-use interlock.
- Sits between decode (read) and writeback (write) in the pipeline. It is the single storage for architectural integer registers.

---
 rtl/regfile_pkg.sv | 43 ++++
 rtl/regfile_rd_port.sv | 59 +++++
 rtl/regfile_mp.sv | 111 +++++++++++
 tb/tb_regfile_mp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The resolve function works on vectors padded to the largest legal port/address/data sizes.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int MAX_NWR   = 4;
    localparam int MAX_AW    = 16;
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic                 hit;
        logic [MAX_WIDTH-1:0] data;
    } wr_res_t;

    function automatic int rf_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Later ports overwrite earlier ones, so the highest-index writer wins.
    function automatic wr_res_t wr_resolve(
        input logic [MAX_NWR-1:0]           wen,
        input logic [MAX_NWR*MAX_AW-1:0]    waddr,
        input logic [MAX_NWR*MAX_WIDTH-1:0] wdata,
        input logic [MAX_AW-1:0]            idx
    );
        wr_res_t res;
        res = '0;
        for (int j = 0; j < MAX_NWR; j++) begin
            if (wen[j] && (waddr[j*MAX_AW +: MAX_AW] == idx)) begin
                res.hit  = 1'b1;
                res.data = wdata[j*MAX_WIDTH +: MAX_WIDTH];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: read mux, zero check, same-edge write bypass,
// and the stall-held rdata/rbusy register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = rf_clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clk_en,
    input  logic                         i_stall,
    input  logic [AW-1:0]                i_raddr,
    input  logic [DEPTH*WIDTH-1:0]       i_mem_flat,
    input  logic [DEPTH-1:0]             i_pend,
    input  logic [DEPTH-1:0]             i_pend_nxt,
    input  logic [MAX_NWR-1:0]           i_wen_pad,
    input  logic [MAX_NWR*MAX_AW-1:0]    i_waddr_pad,
    input  logic [MAX_NWR*MAX_WIDTH-1:0] i_wdata_pad,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_rbusy
);

    logic [WIDTH-1:0] w_rd_data;
    logic             w_rd_busy;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rbusy;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_res_t w_byp;
        w_byp     = wr_resolve(i_wen_pad, i_waddr_pad, i_wdata_pad, MAX_AW'(i_raddr));
        w_rd_data = i_mem_flat[i_raddr*WIDTH +: WIDTH];
        w_rd_busy = i_pend[i_raddr];
        if (BYPASS) begin
            if (w_byp.hit) w_rd_data = w_byp.data[WIDTH-1:0];
            w_rd_busy = i_pend_nxt[i_raddr];
        end
        if (ZERO_REG && (i_raddr == '0)) w_rd_data = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_rbusy <= 1'b0;
        end else if (i_clk_en && !i_stall) begin
            r_rdata <= w_rd_data;
            r_rbusy <= w_rd_busy;
        end
    end

    assign o_rdata = r_rdata;
    assign o_rbusy = r_rbusy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with write priority,
// optional write-first bypass and a per-register pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    parameter int DBG_IDX  = 1,
    localparam int AW      = rf_clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 stall,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*WIDTH-1:0] wdata,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_addr,
    output logic                 any_pending,
    output logic [WIDTH-1:0]     dbg_val
);

    localparam logic [AW-1:0] DBG_A = AW'(DBG_IDX);

    logic [WIDTH-1:0]             r_mem [DEPTH];
    logic [DEPTH-1:0]             r_pend;
    logic [DEPTH-1:0]             w_hit;
    logic [WIDTH-1:0]             w_hit_data [DEPTH];
    logic [DEPTH-1:0]             w_pend_nxt;
    logic [DEPTH*WIDTH-1:0]       w_mem_flat;
    logic [MAX_NWR-1:0]           w_wen_pad;
    logic [MAX_NWR*MAX_AW-1:0]    w_waddr_pad;
    logic [MAX_NWR*MAX_WIDTH-1:0] w_wdata_pad;

    // Writes to register 0 are removed here so neither storage nor bypass ever sees them.
    always_comb begin
        w_wen_pad   = '0;
        w_waddr_pad = '0;
        w_wdata_pad = '0;
        for (int j = 0; j < NWR; j++) begin
            w_wen_pad[j] = wen[j] && !(ZERO_REG && (waddr[j*AW +: AW] == '0));
            w_waddr_pad[j*MAX_AW +: AW]       = waddr[j*AW +: AW];
            w_wdata_pad[j*MAX_WIDTH +: WIDTH] = wdata[j*WIDTH +: WIDTH];
        end
    end

    // A new producer (sb_set) supersedes a same-edge completing write.
    always_comb begin
        w_hit      = '0;
        w_pend_nxt = r_pend;
        w_mem_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_res_t w_res;
            w_res         = wr_resolve(w_wen_pad, w_waddr_pad, w_wdata_pad, MAX_AW'(i));
            w_hit[i]      = w_res.hit;
            w_hit_data[i] = w_res.data[WIDTH-1:0];
            if (w_res.hit) w_pend_nxt[i] = 1'b0;
            if (sb_set && (sb_addr == AW'(i))) w_pend_nxt[i] = 1'b1;
            if (ZERO_REG && (i == 0)) w_pend_nxt[i] = 1'b0;
            w_mem_flat[i*WIDTH +: WIDTH] = r_mem[i];
        end
    end

    // NOTE: storage is flop-based and must clear on reset, so the array sits inside the reset branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_pend <= '0;
        end else if (clk_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_hit[i]) r_mem[i] <= w_hit_data[i];
            end
            r_pend <= w_pend_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rd_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .clk         (clk),
            .rst         (rst),
            .i_clk_en    (clk_en),
            .i_stall     (stall),
            .i_raddr     (raddr[k*AW +: AW]),
            .i_mem_flat  (w_mem_flat),
            .i_pend      (r_pend),
            .i_pend_nxt  (w_pend_nxt),
            .i_wen_pad   (w_wen_pad),
            .i_waddr_pad (w_waddr_pad),
            .i_wdata_pad (w_wdata_pad),
            .o_rdata     (rdata[k*WIDTH +: WIDTH]),
            .o_rbusy     (rbusy[k])
        );
    end

    assign any_pending = |r_pend;
    assign dbg_val     = r_mem[DBG_A];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one write-first and one read-before-write
// instance share the stimulus; expected values are hand-computed constants.
module tb_regfile_mp;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        stall;
    logic [9:0]  raddr;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        sb_set;
    logic [4:0]  sb_addr;

    logic [63:0] rdata, rdata_nb;
    logic [1:0]  rbusy, rbusy_nb;
    logic        any_pending, any_pending_nb;
    logic [31:0] dbg_val, dbg_val_nb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .any_pending(any_pending), .dbg_val(dbg_val)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall),
        .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .any_pending(any_pending_nb), .dbg_val(dbg_val_nb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wen[p] = 1'b1;
        waddr[p*AW +: AW] = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    task automatic idle();
        wen    = '0;
        sb_set = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; stall = 1'b0;
        raddr = '0; wen = '0; waddr = '0; wdata = '0;
        sb_set = 1'b0; sb_addr = '0;
        repeat (2) tick();
        check("rst_rdata", rdata, 64'h0);
        check("rst_rbusy", {62'h0, rbusy}, 64'h0);
        check("rst_pending", {63'h0, any_pending}, 64'h0);
        check("rst_dbg", {32'h0, dbg_val}, 64'h0);
        rst = 1'b0;

        // Reset mid-run
        wr(0, 5, 32'hDEADBEEF); wr(1, 1, 32'h0000CAFE);
        sb_set = 1'b1; sb_addr = 5'd6;
        tick(); idle();
        check("dbg_r1", {32'h0, dbg_val}, 64'h0000CAFE);
        check("pend_r6", {63'h0, any_pending}, 64'h1);
        rd(0, 5);
        tick();
        check("read_r5", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rdata", rdata, 64'h0);
        check("async_rst_pending", {63'h0, any_pending}, 64'h0);
        check("async_rst_dbg", {32'h0, dbg_val}, 64'h0);
        wr(0, 5, 32'h00000777);
        tick(); idle();
        rst = 1'b0;
        tick();
        check("r5_after_rst", {32'h0, rdata[31:0]}, 64'h0);

        // Zero register
        wr(0, 0, 32'h1234); wr(1, 0, 32'h1234);
        sb_set = 1'b1; sb_addr = 5'd0;
        rd(0, 0);
        tick(); idle();
        check("r0_pending", {63'h0, any_pending}, 64'h0);
        tick();
        check("r0_read", {32'h0, rdata[31:0]}, 64'h0);

        // Write-port priority
        wr(0, 3, 32'hAAAA0000); wr(1, 3, 32'h5555FFFF);
        tick(); idle();
        rd(1, 3);
        tick();
        check("conflict_r3", {32'h0, rdata[63:32]}, 64'h5555FFFF);
        check("conflict_r3_nb", {32'h0, rdata_nb[63:32]}, 64'h5555FFFF);
        wr(0, 8, 32'h81); wr(1, 8, 32'h82); rd(1, 8);
        tick(); idle();
        check("byp_conflict_r8", {32'h0, rdata[63:32]}, 64'h82);
        check("nobyp_conflict_r8", {32'h0, rdata_nb[63:32]}, 64'h0);

        // Bypass vs read-before-write
        rd(0, 7); wr(0, 7, 32'h42);
        tick(); idle();
        check("byp_r7", {32'h0, rdata[31:0]}, 64'h42);
        check("nobyp_r7_old", {32'h0, rdata_nb[31:0]}, 64'h0);
        tick();
        check("nobyp_r7_new", {32'h0, rdata_nb[31:0]}, 64'h42);

        // Stall hold
        wr(1, 2, 32'h11);
        tick(); idle();
        rd(0, 2);
        tick();
        check("r2_pre_stall", {32'h0, rdata[31:0]}, 64'h11);
        stall = 1'b1; wr(0, 2, 32'h22);
        tick(); idle();
        check("stall_c1", {32'h0, rdata[31:0]}, 64'h11);
        tick();
        check("stall_c2", {32'h0, rdata[31:0]}, 64'h11);
        tick();
        check("stall_c3", {32'h0, rdata_nb[31:0]}, 64'h11);
        stall = 1'b0;
        tick();
        check("stall_release", {32'h0, rdata[31:0]}, 64'h22);
        check("stall_release_nb", {32'h0, rdata_nb[31:0]}, 64'h22);

        // clk_en=0 freezes everything
        clk_en = 1'b0; wr(0, 2, 32'h33);
        tick(); idle();
        check("clken_hold", {32'h0, rdata[31:0]}, 64'h22);
        clk_en = 1'b1;
        tick();
        check("clken_no_write", {32'h0, rdata[31:0]}, 64'h22);

        // Scoreboard
        sb_set = 1'b1; sb_addr = 5'd9;
        tick(); idle();
        check("sb_pending", {63'h0, any_pending}, 64'h1);
        rd(0, 9); rd(1, 9);
        tick();
        check("sb_rbusy", {62'h0, rbusy}, 64'h3);
        check("sb_rbusy_nb", {62'h0, rbusy_nb}, 64'h3);
        wr(0, 9, 32'h99); sb_set = 1'b1; sb_addr = 5'd9;
        tick(); idle();
        check("set_wins_pending", {63'h0, any_pending}, 64'h1);
        check("set_wins_rbusy", {62'h0, rbusy}, 64'h3);
        check("set_wins_rdata", {32'h0, rdata[31:0]}, 64'h99);
        check("set_wins_rdata_nb", {32'h0, rdata_nb[31:0]}, 64'h0);
        clk_en = 1'b0; wr(1, 9, 32'h5); sb_set = 1'b1; sb_addr = 5'd10;
        tick(); idle();
        clk_en = 1'b1;
        check("clken_pend_hold", {63'h0, any_pending}, 64'h1);
        wr(0, 9, 32'h100);
        tick(); idle();
        check("clear_rbusy", {62'h0, rbusy}, 64'h0);
        check("clear_rbusy_nb", {62'h0, rbusy_nb}, 64'h3);
        check("clear_pending", {63'h0, any_pending}, 64'h0);
        check("clear_pending_nb", {63'h0, any_pending_nb}, 64'h0);
        check("clear_rdata", {32'h0, rdata[31:0]}, 64'h100);
        check("clear_rdata_nb", {32'h0, rdata_nb[31:0]}, 64'h99);
        tick();
        check("clear_rbusy_nb2", {62'h0, rbusy_nb}, 64'h0);
        check("clear_rdata_nb2", {32'h0, rdata_nb[63:32]}, 64'h100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
